// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the multi-cycle sequencer and the shared single-port memory.
interface multicycle_ctrl_if;
    logic Mem_req;
    logic Mem_rdy;
    logic Iord;
    logic Wmem;

    modport master (
        output Mem_req,
        output Iord,
        output Wmem,
        input  Mem_rdy
    );

    modport slave (
        input  Mem_req,
        input  Iord,
        input  Wmem,
        output Mem_rdy
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset core: IF/ID/EX/MEM/WB over a shared memory.
// State and instruction class are registered; strobes and steering decode from them combinationally.
module multicycle_ctrl (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Func,
    input  logic               Z,
    multicycle_ctrl_if.master  mem,
    output logic               Irwr,
    output logic               Pcwr,
    output logic [1:0]         Pcsrc,
    output logic               Wreg,
    output logic               Regrt,
    output logic               Se,
    output logic               Aluqb,
    output logic [1:0]         Aluc,
    output logic [1:0]         Reg2reg,
    output logic               Reglui,
    output logic               sRight,
    output logic               sArith,
    output logic               Illegal,
    output logic               Retire,
    output logic [2:0]         State
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [4:0] {
        C_NONE, C_ADD, C_SUB, C_AND, C_OR, C_SLL, C_SRL, C_SRA,
        C_ADDI, C_ANDI, C_ORI, C_LW, C_SW, C_BEQ, C_BNE, C_LUI, C_J, C_ILL
    } cls_t;

    state_t r_state;
    state_t w_next;
    cls_t   r_cls;
    cls_t   w_dec;
    logic   w_mem_req;
    logic   w_iord;
    logic   w_wmem;

    // Instruction class from the IR fields; only consumed in ID.
    always_comb begin
        w_dec = C_ILL;
        case (Op)
            6'b000000: begin
                case (Func)
                    6'b100000: w_dec = C_ADD;
                    6'b100010: w_dec = C_SUB;
                    6'b100100: w_dec = C_AND;
                    6'b100101: w_dec = C_OR;
                    6'b000000: w_dec = C_SLL;
                    6'b000010: w_dec = C_SRL;
                    6'b000011: w_dec = C_SRA;
                    default:   w_dec = C_ILL;
                endcase
            end
            6'b001000: w_dec = C_ADDI;
            6'b001100: w_dec = C_ANDI;
            6'b001101: w_dec = C_ORI;
            6'b100011: w_dec = C_LW;
            6'b101011: w_dec = C_SW;
            6'b000100: w_dec = C_BEQ;
            6'b000101: w_dec = C_BNE;
            6'b001111: w_dec = C_LUI;
            6'b000010: w_dec = C_J;
            default:   w_dec = C_ILL;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IF;
            r_cls   <= C_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID) begin
                r_cls <= w_dec;
            end
        end
    end

    // Next state and strobes; Reset masks every strobe so an aborted instruction writes nothing.
    always_comb begin
        w_next    = S_IF;
        w_mem_req = 1'b0;
        w_iord    = 1'b0;
        w_wmem    = 1'b0;
        Irwr      = 1'b0;
        Pcwr      = 1'b0;
        Pcsrc     = 2'b00;
        Wreg      = 1'b0;
        Illegal   = 1'b0;
        Retire    = 1'b0;
        case (r_state)
            S_IF: begin
                w_mem_req = 1'b1;
                if (mem.Mem_rdy) begin
                    Irwr   = 1'b1;
                    Pcwr   = 1'b1;
                    w_next = S_ID;
                end else begin
                    w_next = S_IF;
                end
            end
            S_ID: begin
                case (w_dec)
                    C_J: begin
                        Pcwr   = 1'b1;
                        Pcsrc  = 2'b11;
                        Retire = 1'b1;
                        w_next = S_IF;
                    end
                    C_LUI:   w_next = S_WB;
                    C_ILL: begin
                        Illegal = 1'b1;
                        w_next  = S_IF;
                    end
                    default: w_next = S_EX;
                endcase
            end
            S_EX: begin
                case (r_cls)
                    C_BEQ, C_BNE: begin
                        Pcwr   = (r_cls == C_BEQ) ? Z : !Z;
                        Pcsrc  = 2'b10;
                        Retire = 1'b1;
                        w_next = S_IF;
                    end
                    C_LW, C_SW: w_next = S_MEM;
                    default:    w_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_wmem    = (r_cls == C_SW);
                if (!mem.Mem_rdy) begin
                    w_next = S_MEM;
                end else if (r_cls == C_LW) begin
                    w_next = S_WB;
                end else begin
                    Retire = (r_cls == C_SW);
                    w_next = S_IF;
                end
            end
            S_WB: begin
                Wreg   = 1'b1;
                Retire = 1'b1;
                w_next = S_IF;
            end
            default: w_next = S_IF;
        endcase
        if (Reset) begin
            w_mem_req = 1'b0;
            w_wmem    = 1'b0;
            Irwr      = 1'b0;
            Pcwr      = 1'b0;
            Wreg      = 1'b0;
            Illegal   = 1'b0;
            Retire    = 1'b0;
        end
    end

    // Datapath steering, held from EX through WB and zero while fetching/decoding.
    always_comb begin
        Regrt   = 1'b0;
        Se      = 1'b0;
        Aluqb   = 1'b0;
        Aluc    = 2'b00;
        Reg2reg = 2'b00;
        Reglui  = 1'b0;
        sRight  = 1'b0;
        sArith  = 1'b0;
        if (r_state == S_EX || r_state == S_MEM || r_state == S_WB) begin
            Reg2reg = 2'b01;
            case (r_cls)
                C_ADD:  Aluqb = 1'b1;
                C_SUB:  begin Aluqb = 1'b1; Aluc = 2'b01; end
                C_AND:  begin Aluqb = 1'b1; Aluc = 2'b10; end
                C_OR:   begin Aluqb = 1'b1; Aluc = 2'b11; end
                C_SLL:  Reg2reg = 2'b10;
                C_SRL:  begin Reg2reg = 2'b10; sRight = 1'b1; end
                C_SRA:  begin Reg2reg = 2'b10; sRight = 1'b1; sArith = 1'b1; end
                C_ADDI: begin Regrt = 1'b1; Se = 1'b1; end
                C_ANDI: begin Regrt = 1'b1; Aluc = 2'b10; end
                C_ORI:  begin Regrt = 1'b1; Aluc = 2'b11; end
                C_LW:   begin Regrt = 1'b1; Se = 1'b1; Reg2reg = 2'b00; end
                C_SW:   begin Regrt = 1'b1; Se = 1'b1; end
                C_BEQ, C_BNE: begin
                    Regrt = 1'b1;
                    Se    = 1'b1;
                    Aluqb = 1'b1;
                    Aluc  = 2'b01;
                end
                C_LUI:  begin Regrt = 1'b1; Reglui = 1'b1; end
                default: ;
            endcase
        end
    end

    assign mem.Mem_req = w_mem_req;
    assign mem.Iord    = w_iord;
    assign mem.Wmem    = w_wmem;
    assign State       = r_state;

endmodule
